updown_counter: RTL and testbench

UPDOWN_COUNTER -- requirements
Module: updown_counter

---
 rtl/counter_pkg.sv | 17 +
 rtl/counter_prescaler.sv | 38 +++
 rtl/updown_counter.sv | 80 ++++++++
 tb/tb_updown_counter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter.
// Mode selectors and a constant-foldable ceil-log2 for sizing.
package counter_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Step strobe generator: one Tick every PRESCALE enabled cycles.
// Collapses to a wire when PRESCALE is 1.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic ClkIn,
  input  logic Rst,
  input  logic Clr,
  input  logic En,
  output logic Tick
);

  if (PRESCALE <= 1) begin : g_bypass
    logic unused_ok;
    assign unused_ok = ^{ClkIn, Rst, Clr};
    assign Tick = En;
  end else begin : g_div
    localparam int unsigned PW = clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;
    logic          last;

    assign last = (cnt == LAST);
    assign Tick = En & last;

    always_ff @(posedge ClkIn) begin
      if (Rst || Clr) begin
        cnt <= '0;
      end else if (En) begin
        cnt <= last ? '0 : cnt + PW'(1);
      end
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Up/down counter with wrap or saturate limit, prescaler,
// clear/load, terminal-count pulse and sticky overflow flag.
module updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned     SATURATE = 0,
  parameter int unsigned     PRESCALE = 1
) (
  input  logic             ClkIn,
  input  logic             Rst,
  input  logic             En,
  input  logic             Up,
  input  logic             Clear,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  output logic [WIDTH-1:0] Count,
  output logic             Tc,
  output logic             Ovf
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
  localparam bit SAT = (SATURATE == MODE_SAT);

  logic             tick;
  logic [WIDTH-1:0] step_val;
  logic             bound;
  logic [WIDTH-1:0] load_sat;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .ClkIn (ClkIn),
    .Rst   (Rst),
    .Clr   (Clear | Load),
    .En    (En),
    .Tick  (tick)
  );

  assign load_sat = (LoadVal > MAX) ? MAX : LoadVal;

  always_comb begin
    step_val = Count;
    bound    = 1'b0;
    if (Up) begin
      if (Count >= MAX) begin
        bound    = 1'b1;
        step_val = SAT ? Count : '0;
      end else begin
        step_val = Count + WIDTH'(1);
      end
    end else begin
      if (Count == '0) begin
        bound    = 1'b1;
        step_val = SAT ? Count : MAX;
      end else begin
        step_val = Count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge ClkIn) begin
    if (Rst || Clear) begin
      Count <= '0;
      Tc    <= 1'b0;
      Ovf   <= 1'b0;
    end else if (Load) begin
      Count <= load_sat;
      Tc    <= 1'b0;
    end else if (tick) begin
      Count <= step_val;
      Tc    <= bound;
      if (bound) Ovf <= 1'b1;
    end else begin
      Tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench: wrap, saturate and prescaled instances
// share one stimulus bus; each task checks the relevant ones.
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, clear, load;
  logic [3:0] load_val;

  logic [3:0] cnt_w, cnt_s, cnt_p;
  logic       tc_w, tc_s, tc_p;
  logic       ovf_w, ovf_s, ovf_p;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  updown_counter #(
    .WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(1)
  ) u_wrap (
    .ClkIn(clk), .Rst(rst), .En(en), .Up(up),
    .Clear(clear), .Load(load), .LoadVal(load_val),
    .Count(cnt_w), .Tc(tc_w), .Ovf(ovf_w)
  );

  updown_counter #(
    .WIDTH(4), .MAX_VAL(9), .SATURATE(1), .PRESCALE(1)
  ) u_sat (
    .ClkIn(clk), .Rst(rst), .En(en), .Up(up),
    .Clear(clear), .Load(load), .LoadVal(load_val),
    .Count(cnt_s), .Tc(tc_s), .Ovf(ovf_s)
  );

  updown_counter #(
    .WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(3)
  ) u_pre (
    .ClkIn(clk), .Rst(rst), .En(en), .Up(up),
    .Clear(clear), .Load(load), .LoadVal(load_val),
    .Count(cnt_p), .Tc(tc_p), .Ovf(ovf_p)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; en = 0; up = 1; clear = 0; load = 0; load_val = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; en = 1; clear = 1; load = 1; load_val = 4'd7;
    step();
    checks++;
    if ({cnt_w, tc_w, ovf_w} !== 6'd0) begin
      errors++;
      $display("FAIL reset_wrap got cnt=%0d tc=%b ovf=%b want 0 0 0",
               cnt_w, tc_w, ovf_w);
    end
    checks++;
    if ({cnt_s, tc_s, ovf_s} !== 6'd0) begin
      errors++;
      $display("FAIL reset_sat got cnt=%0d tc=%b ovf=%b want 0 0 0",
               cnt_s, tc_s, ovf_s);
    end
    checks++;
    if ({cnt_p, tc_p, ovf_p} !== 6'd0) begin
      errors++;
      $display("FAIL reset_pre got cnt=%0d tc=%b ovf=%b want 0 0 0",
               cnt_p, tc_p, ovf_p);
    end
  endtask

  task automatic test_wrap_up();
    logic [3:0] exp_w [12] = '{1,2,3,4,5,6,7,8,9,0,1,2};
    logic [3:0] exp_s [12] = '{1,2,3,4,5,6,7,8,9,9,9,9};
    do_reset();
    en = 1; up = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (cnt_w !== exp_w[i] || tc_w !== (i == 9) || ovf_w !== (i >= 9)) begin
        errors++;
        $display("FAIL wrap_up[%0d] got cnt=%0d tc=%b ovf=%b want %0d %b %b",
                 i, cnt_w, tc_w, ovf_w, exp_w[i], i == 9, i >= 9);
      end
      checks++;
      if (cnt_s !== exp_s[i] || tc_s !== (i >= 9) || ovf_s !== (i >= 9)) begin
        errors++;
        $display("FAIL sat_up[%0d] got cnt=%0d tc=%b ovf=%b want %0d %b %b",
                 i, cnt_s, tc_s, ovf_s, exp_s[i], i >= 9, i >= 9);
      end
    end
  endtask

  task automatic test_sat_down();
    logic [3:0] exp_w [3] = '{9,8,7};
    do_reset();
    en = 1; up = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (cnt_s !== 4'd0 || tc_s !== 1'b1 || ovf_s !== 1'b1) begin
        errors++;
        $display("FAIL sat_down[%0d] got cnt=%0d tc=%b ovf=%b want 0 1 1",
                 i, cnt_s, tc_s, ovf_s);
      end
      checks++;
      if (cnt_w !== exp_w[i] || tc_w !== (i == 0) || ovf_w !== 1'b1) begin
        errors++;
        $display("FAIL wrap_down[%0d] got cnt=%0d tc=%b ovf=%b want %0d %b 1",
                 i, cnt_w, tc_w, ovf_w, exp_w[i], i == 0);
      end
    end
    clear = 1;
    step();
    clear = 0;
    checks++;
    if (cnt_s !== 4'd0 || tc_s !== 1'b0 || ovf_s !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear got cnt=%0d tc=%b ovf=%b want 0 0 0",
               cnt_s, tc_s, ovf_s);
    end
  endtask

  task automatic test_load();
    do_reset();
    en = 1; up = 0;
    step();
    up = 1; load = 1; load_val = 4'd15;
    step();
    load = 0;
    checks++;
    if (cnt_w !== 4'd9 || tc_w !== 1'b0 || ovf_w !== 1'b1) begin
      errors++;
      $display("FAIL load_clamp got cnt=%0d tc=%b ovf=%b want 9 0 1",
               cnt_w, tc_w, ovf_w);
    end
    checks++;
    if (cnt_s !== 4'd9 || tc_s !== 1'b0) begin
      errors++;
      $display("FAIL load_sat got cnt=%0d tc=%b want 9 0", cnt_s, tc_s);
    end
  endtask

  task automatic test_prescale();
    logic       en_seq [4] = '{1, 1, 0, 1};
    logic [3:0] exp_p  [4] = '{0, 0, 0, 1};
    do_reset();
    up = 1;
    for (int i = 0; i < 4; i++) begin
      en = en_seq[i];
      step();
      checks++;
      if (cnt_p !== exp_p[i] || tc_p !== 1'b0) begin
        errors++;
        $display("FAIL prescale[%0d] got cnt=%0d tc=%b want %0d 0",
                 i, cnt_p, tc_p, exp_p[i]);
      end
    end
    en = 1;
    step();
    step();
    load = 1; load_val = 4'd4;
    step();
    load = 0;
    step();
    step();
    checks++;
    if (cnt_p !== 4'd4) begin
      errors++;
      $display("FAIL prescale_load_hold got cnt=%0d want 4", cnt_p);
    end
    step();
    checks++;
    if (cnt_p !== 4'd5) begin
      errors++;
      $display("FAIL prescale_load_step got cnt=%0d want 5", cnt_p);
    end
  endtask

  task automatic test_clear_load_rst();
    do_reset();
    load = 1; load_val = 4'd7;
    step();
    clear = 1; load = 1; load_val = 4'd5;
    step();
    clear = 0; load = 0;
    checks++;
    if (cnt_w !== 4'd0) begin
      errors++;
      $display("FAIL clear_over_load got cnt=%0d want 0", cnt_w);
    end
    en = 1; up = 0;
    step();
    checks++;
    if (cnt_w !== 4'd9 || tc_w !== 1'b1 || ovf_w !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_state got cnt=%0d tc=%b ovf=%b want 9 1 1",
               cnt_w, tc_w, ovf_w);
    end
    rst = 1; clear = 1; load = 1; load_val = 4'd5;
    step();
    rst = 0; clear = 0; load = 0; up = 1;
    checks++;
    if (cnt_w !== 4'd0 || tc_w !== 1'b0 || ovf_w !== 1'b0) begin
      errors++;
      $display("FAIL rst_override got cnt=%0d tc=%b ovf=%b want 0 0 0",
               cnt_w, tc_w, ovf_w);
    end
    step();
    step();
    checks++;
    if (cnt_p !== 4'd0) begin
      errors++;
      $display("FAIL rst_presc_hold got cnt=%0d want 0", cnt_p);
    end
    step();
    checks++;
    if (cnt_p !== 4'd1 || tc_p !== 1'b0) begin
      errors++;
      $display("FAIL rst_presc_step got cnt=%0d tc=%b want 1 0", cnt_p, tc_p);
    end
  endtask

  task automatic test_back_to_back();
    logic       dir [4] = '{1, 0, 1, 0};
    logic [3:0] exp [4] = '{6, 5, 6, 5};
    do_reset();
    load = 1; load_val = 4'd5;
    step();
    load = 0; en = 1;
    for (int i = 0; i < 4; i++) begin
      up = dir[i];
      step();
      checks++;
      if (cnt_w !== exp[i] || tc_w !== 1'b0) begin
        errors++;
        $display("FAIL toggle[%0d] got cnt=%0d tc=%b want %0d 0",
                 i, cnt_w, tc_w, exp[i]);
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_load();
    test_prescale();
    test_clear_load_rst();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
